// File: rtl/cache_way_seq.sv
// ============================================================================
// cache_way_seq : address/strobe sequencer for one cache way (tag LUTRAM +
// data SDP RAM). Optional post-reset invalidate sweep: CACHE_WAY_SEQ_INV_SWEEP_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_way_seq #(
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                i_req_valid,
  output logic                                o_req_ready,
  input  logic [INDEX_WIDTH-1:0]              i_req_index,
  input  logic [TAG_WIDTH-1:0]                i_req_tag,
  input  logic [OFFSET_WIDTH-1:0]             i_req_offset,
  output logic                                o_resp_valid,
  output logic                                o_resp_hit,
  output logic [DATA_WIDTH-1:0]               o_resp_rdata,
  input  logic                                i_refill_start,
  output logic                                o_refill_ready,
  input  logic [INDEX_WIDTH-1:0]              i_refill_index,
  input  logic [TAG_WIDTH-1:0]                i_refill_tag,
  input  logic                                i_refill_valid,
  input  logic [DATA_WIDTH-1:0]               i_refill_data,
  output logic                                o_refill_done,
  output logic                                o_init_busy,
  output logic                                o_tag_we,
  output logic [INDEX_WIDTH-1:0]              o_tag_addr,
  output logic [TAG_WIDTH:0]                  o_tag_din,
  input  logic [TAG_WIDTH:0]                  i_tag_dout,
  output logic                                o_data_wea,
  output logic                                o_data_ena,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] o_data_addra,
  output logic [DATA_WIDTH-1:0]               o_data_dina,
  output logic                                o_data_enb,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] o_data_addrb,
  input  logic [DATA_WIDTH-1:0]               i_data_doutb
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_REFILL = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

`ifdef CACHE_WAY_SEQ_INV_SWEEP_EN
  localparam state_t c_RESET_STATE = S_INIT;
`else
  localparam state_t c_RESET_STATE = S_IDLE;
`endif
  localparam logic [INDEX_WIDTH-1:0]  c_LAST_SET  = '1;
  localparam logic [OFFSET_WIDTH-1:0] c_LAST_WORD = '1;

  state_t                  r_state, w_state_nxt;
  logic [INDEX_WIDTH-1:0]  r_sweep_idx, w_sweep_nxt;
  logic [OFFSET_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [INDEX_WIDTH-1:0]  r_idx;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic                    r_resp_valid;
  logic                    r_resp_hit;
  logic                    w_lookup;
  logic                    w_start;
  logic                    w_hit;

  assign w_hit = i_tag_dout[TAG_WIDTH] && (i_tag_dout[TAG_WIDTH-1:0] == i_req_tag);

  // Everything is gated by resetn so no strobe or handshake leaks while in reset.
  always_comb begin
    w_state_nxt    = r_state;
    w_sweep_nxt    = r_sweep_idx;
    w_cnt_nxt      = r_cnt;
    w_lookup       = 1'b0;
    w_start        = 1'b0;
    o_req_ready    = 1'b0;
    o_refill_ready = 1'b0;
    o_refill_done  = 1'b0;
    o_tag_we       = 1'b0;
    o_tag_addr     = i_req_index;
    o_tag_din      = '0;
    o_data_wea     = 1'b0;
    o_data_ena     = 1'b0;
    o_data_addra   = {r_idx, r_cnt};
    o_data_dina    = i_refill_data;
    o_data_enb     = 1'b0;
    o_data_addrb   = {i_req_index, i_req_offset};
    if (resetn) begin
      case (r_state)
        S_INIT: begin
          o_tag_we    = 1'b1;
          o_tag_addr  = r_sweep_idx;
          w_sweep_nxt = r_sweep_idx + 1'b1;
          if (r_sweep_idx == c_LAST_SET) w_state_nxt = S_IDLE;
        end
        S_IDLE: begin
          o_refill_ready = 1'b1;
          o_req_ready    = !i_refill_start;
          if (i_refill_start) begin
            // Pre-invalidate so an interrupted refill never leaves a stale valid tag.
            w_start     = 1'b1;
            o_tag_we    = 1'b1;
            o_tag_addr  = i_refill_index;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REFILL;
          end else if (i_req_valid) begin
            w_lookup   = 1'b1;
            o_data_enb = 1'b1;
          end
        end
        S_REFILL: begin
          o_tag_addr = r_idx;
          if (i_refill_valid) begin
            o_data_wea = 1'b1;
            o_data_ena = 1'b1;
            w_cnt_nxt  = r_cnt + 1'b1;
            if (r_cnt == c_LAST_WORD) w_state_nxt = S_COMMIT;
          end
        end
        S_COMMIT: begin
          o_tag_we      = 1'b1;
          o_tag_addr    = r_idx;
          o_tag_din     = {1'b1, r_tag};
          o_refill_done = 1'b1;
          w_state_nxt   = S_IDLE;
        end
        default: w_state_nxt = c_RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= c_RESET_STATE;
      r_sweep_idx  <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sweep_idx  <= w_sweep_nxt;
      r_cnt        <= w_cnt_nxt;
      r_resp_valid <= w_lookup;
      r_resp_hit   <= w_lookup & w_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_idx <= i_refill_index;
      r_tag <= i_refill_tag;
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_hit   = r_resp_hit;
  assign o_resp_rdata = i_data_doutb;

`ifdef CACHE_WAY_SEQ_INV_SWEEP_EN
  assign o_init_busy = (r_state == S_INIT);
`else
  assign o_init_busy = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_way_seq.sv
// ============================================================================
// tb_cache_way_seq : self-checking bench for cache_way_seq with tag/data RAM
// models and a lookup scoreboard. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_way_seq;
  localparam int TW = 20, IW = 8, OW = 2, DW = 32;
  localparam int SETS = 1 << IW, WORDS = 1 << OW;
`ifdef CACHE_WAY_SEQ_INV_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0;
  logic req_valid = 0, req_ready, resp_valid, resp_hit;
  logic [IW-1:0] req_index = '0, refill_index = '0, tag_addr;
  logic [TW-1:0] req_tag = '0, refill_tag = '0;
  logic [OW-1:0] req_offset = '0;
  logic [DW-1:0] resp_rdata, refill_data = '0, data_dina, data_doutb;
  logic refill_start = 0, refill_ready, refill_valid = 0, refill_done, init_busy;
  logic tag_we, data_wea, data_ena, data_enb;
  logic [TW:0] tag_din, tag_dout;
  logic [IW+OW-1:0] data_addra, data_addrb;

  cache_way_seq #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .resetn(resetn),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_index(req_index),
    .i_req_tag(req_tag), .i_req_offset(req_offset),
    .o_resp_valid(resp_valid), .o_resp_hit(resp_hit), .o_resp_rdata(resp_rdata),
    .i_refill_start(refill_start), .o_refill_ready(refill_ready),
    .i_refill_index(refill_index), .i_refill_tag(refill_tag),
    .i_refill_valid(refill_valid), .i_refill_data(refill_data),
    .o_refill_done(refill_done), .o_init_busy(init_busy),
    .o_tag_we(tag_we), .o_tag_addr(tag_addr), .o_tag_din(tag_din), .i_tag_dout(tag_dout),
    .o_data_wea(data_wea), .o_data_ena(data_ena), .o_data_addra(data_addra),
    .o_data_dina(data_dina), .o_data_enb(data_enb), .o_data_addrb(data_addrb),
    .i_data_doutb(data_doutb)
  );

  always #5 clk = ~clk;

  // Tag LUTRAM (async read) and data SDP RAM (1-cycle read, same-address write bypass)
  logic [TW:0]   tag_mem [SETS];
  logic [DW-1:0] dmem [SETS*WORDS];
  assign tag_dout = tag_mem[tag_addr];
  always @(posedge clk) begin
    if (tag_we) tag_mem[tag_addr] <= tag_din;
    if (data_ena && data_wea) dmem[data_addra] <= data_dina;
    if (data_enb)
      data_doutb <= (data_ena && data_wea && data_addra == data_addrb) ? data_dina : dmem[data_addrb];
  end

  int n_cmp = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model of the way contents
  bit            ref_valid [SETS];
  logic [TW-1:0] ref_tag   [SETS];
  logic [DW-1:0] ref_data  [SETS*WORDS];

  typedef struct {logic hit; logic [DW-1:0] data; int cyc;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].cyc + 1 == cyc) begin
      mon_e = sb_q.pop_front();
      chk("resp_valid", resp_valid, 1);
      chk("resp_hit", resp_hit, mon_e.hit);
      if (mon_e.hit) chk("resp_rdata", resp_rdata, mon_e.data);
    end else if (resp_valid) begin
      chk("resp_spurious", resp_valid, 0);
    end
    if (req_valid && req_ready) begin
      mon_e.hit  = ref_valid[req_index] && (ref_tag[req_index] == req_tag);
      mon_e.data = ref_data[{req_index, req_offset}];
      mon_e.cyc  = cyc;
      sb_q.push_back(mon_e);
    end
  end

  // Every step: drive just after posedge, sample at negedge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); step(); end
  endtask

  task automatic lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tg, input logic [OW-1:0] off);
    req_valid = 1; req_index = idx; req_tag = tg; req_offset = off;
    @(negedge clk);
    chk("lookup_ready", req_ready, 1);
    step();
    req_valid = 0;
  endtask

  task automatic refill(input logic [IW-1:0] idx, input logic [TW-1:0] tg, input logic [DW-1:0] base,
                        input int bub, input int nbeats);
    int t0;
    refill_start = 1; refill_index = idx; refill_tag = tg;
    @(negedge clk);
    chk("start_refill_ready", refill_ready, 1);
    chk("start_req_ready", req_ready, 0);
    chk("preinv_we", tag_we, 1);
    chk("preinv_addr", tag_addr, idx);
    chk("preinv_din", tag_din, 0);
    t0 = cyc;
    step();
    refill_start = 0;
    ref_valid[idx] = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) repeat (bub) begin
        refill_valid = 0;
        @(negedge clk);
        chk("bubble_done", refill_done, 0);
        chk("bubble_wea", data_wea, 0);
        step();
      end
      refill_valid = 1; refill_data = base * (b + 1);
      @(negedge clk);
      chk("beat_wea", data_wea & data_ena, 1);
      chk("beat_addra", data_addra, {idx, b[OW-1:0]});
      chk("beat_dina", data_dina, base * (b + 1));
      chk("beat_req_ready", req_ready, 0);
      chk("beat_refill_ready", refill_ready, 0);
      step();
      ref_data[{idx, b[OW-1:0]}] = base * (b + 1);
      refill_valid = 0;
    end
    if (nbeats == WORDS) begin
      @(negedge clk);
      chk("commit_done", refill_done, 1);
      chk("commit_latency", cyc - t0, 1 + WORDS + (WORDS - 1) * bub);
      chk("commit_we", tag_we, 1);
      chk("commit_addr", tag_addr, idx);
      chk("commit_din", tag_din, {1'b1, tg});
      chk("commit_req_ready", req_ready, 0);
      step();
      ref_valid[idx] = 1; ref_tag[idx] = tg;
    end
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    @(negedge clk);
    while (init_busy && n < 300) begin n++; @(negedge clk); end
    step();
    chk("sweep_len", n, SWEEP ? SETS : 0);
    if (SWEEP) for (int i = 0; i < SETS; i++) ref_valid[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SETS; i++) begin
      tag_mem[i]   = SWEEP ? {1'b1, TW'($urandom)} : '0;
      ref_valid[i] = 0;
      ref_tag[i]   = '0;
    end
    if (SWEEP) tag_mem[5] = {1'b1, 20'h00005};
    for (int i = 0; i < SETS * WORDS; i++) begin dmem[i] = $urandom; ref_data[i] = dmem[i]; end

    // Reset: handshakes low, init_busy at its reset value
    refill_start = 1; req_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_refill_ready", refill_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_refill_done", refill_done, 0);
      chk("rst_init_busy", init_busy, SWEEP);
      step();
    end
    refill_start = 0; req_valid = 0; resetn = 1;

    if (SWEEP) begin
      for (int i = 0; i < SETS; i++) begin
        @(negedge clk);
        chk("sweep_busy", init_busy, 1);
        chk("sweep_we", tag_we, 1);
        chk("sweep_addr", tag_addr, i);
        chk("sweep_din", tag_din, 0);
        chk("sweep_req_ready", req_ready, 0);
        step();
      end
    end
    @(negedge clk);
    chk("idle_busy", init_busy, 0);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_refill_ready", refill_ready, 1);
    step();

    lookup(8'd5, 20'h00005, 2'd0);
    refill(8'h12, 20'hABCDE, 32'h11, 0, WORDS);
    lookup(8'h12, 20'hABCDE, 2'd2);
    lookup(8'h12, 20'hABCDF, 2'd2);
    for (int o = 0; o < WORDS; o++) lookup(8'h12, 20'hABCDE, o[OW-1:0]);
    idle(1);

    // Stray refill beat outside REFILL must not write
    refill_valid = 1; refill_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stray_wea", data_wea | data_ena, 0);
    step();
    refill_valid = 0;

    refill(8'h34, 20'h12345, 32'h0101_0101, 2, WORDS);
    lookup(8'h34, 20'h12345, 2'd3);
    lookup(8'h34, 20'h12345, 2'd0);

    // Lookup held against a same-cycle refill start
    req_valid = 1; req_index = 8'h56; req_tag = 20'h0AAAA; req_offset = 2'd1;
    refill(8'h56, 20'h0AAAA, 32'h2020_0003, 1, WORDS);
    @(negedge clk);
    chk("post_commit_req_ready", req_ready, 1);
    step();
    req_valid = 0;
    idle(1);

    // Reset in the middle of a refill over a valid line
    refill(8'h12, 20'h77777, 32'h0F0F_0F0F, 0, 2);
    resetn = 0;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_refill_ready", refill_ready, 0);
    step();
    resetn = 1;
    wait_sweep();
    lookup(8'h12, 20'hABCDE, 2'd2);
    lookup(8'h12, 20'h77777, 2'd0);
    lookup(8'h34, 20'h12345, 2'd1);
    idle(3);
    chk("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
